// File: rtl/scl180_eco_strap_capture.sv
// scl180_eco_strap_capture
//
// Turns the SCL180 spare-cell tie-off straps into a clean, registered
// configuration word. After reset (or a rescan request) the block waits
// SETTLE_CYCLES, then samples the synchronized straps every cycle until
// SAMPLES consecutive identical samples are seen, and commits that value.
// If MAX_SAMPLES samples pass without such a run, the latest sample is
// committed anyway and the sticky mismatch flag is raised.
//
// Ports:
//   wb_clk_i       single clock
//   wb_rst_i       synchronous, active-high reset
//   strap_i        raw strap nets (asynchronous), NUM_STRAPS wide
//   rescan_i       one-cycle rescan request, honoured only when idle
//   strap_o        committed strap word
//   strap_valid_o  high once any commit has occurred
//   busy_o         high while settling or sampling
//   changed_o      one-cycle pulse when a rescan commits a different word
//   mismatch_o     sticky: unstable samples seen or sample budget exhausted

module scl180_eco_strap_capture #(
    parameter int NUM_STRAPS    = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLES       = 3,
    parameter int MAX_SAMPLES   = 64
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [NUM_STRAPS-1:0] strap_i,
    input  logic                  rescan_i,
    output logic [NUM_STRAPS-1:0] strap_o,
    output logic                  strap_valid_o,
    output logic                  busy_o,
    output logic                  changed_o,
    output logic                  mismatch_o
);

    localparam int SET_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
    localparam int SMP_W = $clog2(MAX_SAMPLES + 1);

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        SAMPLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state;
    logic [NUM_STRAPS-1:0]   sync_p0;
    logic [NUM_STRAPS-1:0]   sync_p1;
    logic [NUM_STRAPS-1:0]   last_sample;
    logic [SET_W-1:0]        settle_cnt;
    logic [SMP_W-1:0]        sample_cnt;
    logic [SMP_W-1:0]        match_cnt;

    logic [SMP_W-1:0]        sample_cnt_nxt;
    logic [SMP_W-1:0]        match_cnt_nxt;
    logic                    first_sample;
    logic                    same_sample;
    logic                    run_hit;
    logic                    budget_hit;

    // Sample-path decisions for the capture taking place this cycle.
    always_comb begin
        sample_cnt_nxt = sample_cnt + SMP_W'(1);
        first_sample   = (sample_cnt == '0);
        same_sample    = (sync_p1 == last_sample);
        // The first capture of a scan opens a fresh run of length one.
        if (first_sample || !same_sample) begin
            match_cnt_nxt = SMP_W'(1);
        end else begin
            match_cnt_nxt = match_cnt + SMP_W'(1);
        end
        run_hit    = (match_cnt_nxt == SMP_W'(SAMPLES));
        budget_hit = (sample_cnt_nxt == SMP_W'(MAX_SAMPLES));
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_p0       <= '0;
            sync_p1       <= '0;
            state         <= SETTLE;
            settle_cnt    <= '0;
            sample_cnt    <= '0;
            match_cnt     <= '0;
            last_sample   <= '0;
            strap_o       <= '0;
            strap_valid_o <= 1'b0;
            busy_o        <= 1'b1;
            changed_o     <= 1'b0;
            mismatch_o    <= 1'b0;
        end else begin
            // Stage p0/p1: two-flop synchronizer for the asynchronous straps
            sync_p0   <= strap_i;
            sync_p1   <= sync_p0;
            changed_o <= 1'b0;

            // FSM stage: consumes sync_p1
            case (state)
                SETTLE: begin
                    if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                        state      <= SAMPLE;
                        settle_cnt <= '0;
                        sample_cnt <= '0;
                        match_cnt  <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end

                SAMPLE: begin
                    last_sample <= sync_p1;
                    sample_cnt  <= sample_cnt_nxt;
                    match_cnt   <= match_cnt_nxt;
                    if (!first_sample && !same_sample) begin
                        mismatch_o <= 1'b1;
                    end
                    // A stable run wins over the budget when both land on
                    // the same sample; only a budget-forced commit flags.
                    if (run_hit || budget_hit) begin
                        strap_o       <= sync_p1;
                        strap_valid_o <= 1'b1;
                        changed_o     <= strap_valid_o && (sync_p1 != strap_o);
                        busy_o        <= 1'b0;
                        state         <= DONE;
                        if (!run_hit) begin
                            mismatch_o <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    if (rescan_i) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                        busy_o     <= 1'b1;
                    end
                end

                default: begin
                    state      <= SETTLE;
                    settle_cnt <= '0;
                    busy_o     <= 1'b1;
                end
            endcase
        end
    end

endmodule
